// File: rtl/mii_elastic_buff.sv
// Single-clock elastic buffer for MII byte/nibble streams with independent read/write strobes.
// Frames are released at a fill threshold; overflow drops the rest of a frame, underflow aborts it.
module mii_elastic_buff #(
    parameter int TCo_C        = 1,
    parameter int DataWidth_C  = 8,
    parameter int DataDepth_C  = 16,
    parameter int StartLevel_C = DataDepth_C / 2
) (
    input  logic                         SysClk,
    input  logic                         Reset_N,
    input  logic                         InMiiClkEn,
    input  logic                         InMiiDataEn,
    input  logic [DataWidth_C-1:0]       InMiiData,
    input  logic                         OutMiiClkEn,
    output logic                         OutMiiDataEn,
    output logic [DataWidth_C-1:0]       OutMiiData,
    output logic                         OutMiiErr,
    output logic [$clog2(DataDepth_C):0] BuffLevel,
    output logic                         OverflowPls,
    output logic                         UnderflowPls,
    output logic [15:0]                  DropFrameCnt
);
    localparam int AW = $clog2(DataDepth_C);
    localparam logic [AW:0] FULL_LVL  = (AW+1)'(DataDepth_C);
    localparam logic [AW:0] START_LVL = (AW+1)'(StartLevel_C);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;

    // TCo_C only shapes simulation clock-to-out; the registers here switch with zero delay.
    if (TCo_C < 0) begin : g_tco_unused
    end

    logic [DataWidth_C:0]   mem_q [DataDepth_C];
    logic [AW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level;
    logic                   in_frame_q, in_frame_d, drop_q, drop_d;
    logic [15:0]            drop_cnt_q, drop_cnt_d;
    logic [1:0]             state_q, state_d;
    logic                   out_en_q, out_en_d, out_err_q, out_err_d;
    logic [DataWidth_C-1:0] out_data_q, out_data_d;
    logic                   ovf_q, unf_q, unf_d;
    logic                   empty, full, wr_req, wr_drop, wr_en, rd_en, head_sof;
    logic [DataWidth_C:0]   head;

    assign level    = wr_ptr_q - rd_ptr_q;
    assign full     = (level == FULL_LVL);
    assign empty    = (level == '0);
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign head_sof = head[DataWidth_C];
    assign wr_req   = InMiiClkEn & InMiiDataEn;
    // Fullness comes from pre-edge registers, so a same-cycle read never rescues a write.
    assign wr_drop  = wr_req & (full | drop_q);
    assign wr_en    = wr_req & ~wr_drop;

    always_comb begin
        in_frame_d = in_frame_q;
        drop_d     = drop_q;
        drop_cnt_d = drop_cnt_q;
        if (InMiiClkEn) begin
            in_frame_d = InMiiDataEn;
            if (!InMiiDataEn) begin
                drop_d = 1'b0;
            end else if (wr_drop) begin
                drop_d = 1'b1;
            end
        end
        if (wr_drop && !drop_q && drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
    end

    always_comb begin
        state_d    = state_q;
        out_en_d   = out_en_q;
        out_err_d  = out_err_q;
        out_data_d = out_data_q;
        rd_en      = 1'b0;
        unf_d      = 1'b0;
        if (OutMiiClkEn) begin
            case (state_q)
                ST_IDLE: begin
                    out_en_d  = 1'b0;
                    out_err_d = 1'b0;
                    if (level >= START_LVL || (!empty && !in_frame_q)) begin
                        rd_en      = 1'b1;
                        out_en_d   = 1'b1;
                        out_data_d = head[DataWidth_C-1:0];
                        state_d    = ST_SEND;
                    end
                end
                ST_SEND: begin
                    out_err_d = 1'b0;
                    if (!empty && !head_sof) begin
                        rd_en      = 1'b1;
                        out_en_d   = 1'b1;
                        out_data_d = head[DataWidth_C-1:0];
                    end else if (!empty || !in_frame_q) begin
                        out_en_d = 1'b0;
                        state_d  = ST_IDLE;
                    end else begin
                        out_en_d   = 1'b1;
                        out_err_d  = 1'b1;
                        out_data_d = '0;
                        unf_d      = 1'b1;
                        state_d    = ST_ABORT;
                    end
                end
                ST_ABORT: begin
                    out_en_d  = 1'b0;
                    out_err_d = 1'b0;
                    if (!empty && !head_sof) begin
                        rd_en = 1'b1;
                    end else if (!empty || !in_frame_q) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        rd_ptr_d = rd_ptr_q + (AW+1)'(rd_en);
    end

    always_ff @(posedge SysClk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {~in_frame_q, InMiiData};
        end
    end

    always_ff @(posedge SysClk or negedge Reset_N) begin
        if (!Reset_N) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            in_frame_q <= 1'b0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
            state_q    <= ST_IDLE;
            out_en_q   <= 1'b0;
            out_err_q  <= 1'b0;
            out_data_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            in_frame_q <= in_frame_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
            state_q    <= state_d;
            out_en_q   <= out_en_d;
            out_err_q  <= out_err_d;
            out_data_q <= out_data_d;
            ovf_q      <= wr_drop;
            unf_q      <= unf_d;
        end
    end

    assign OutMiiDataEn = out_en_q;
    assign OutMiiData   = out_data_q;
    assign OutMiiErr    = out_err_q;
    assign BuffLevel    = level;
    assign OverflowPls  = ovf_q;
    assign UnderflowPls = unf_q;
    assign DropFrameCnt = drop_cnt_q;

endmodule

// File: tb/tb_mii_elastic_buff.sv
// Self-checking bench for mii_elastic_buff: directed frame scenarios plus randomized traffic,
// every cycle compared against a queue-based reference model of the buffer.
module tb_mii_elastic_buff;
    localparam int DEPTH = 16;
    localparam int START = 8;
    localparam int M_IDLE = 0, M_SEND = 1, M_ABORT = 2;

    logic       SysClk, Reset_N;
    logic       InMiiClkEn, InMiiDataEn, OutMiiClkEn;
    logic [7:0] InMiiData, OutMiiData;
    logic       OutMiiDataEn, OutMiiErr, OverflowPls, UnderflowPls;
    logic [4:0] BuffLevel;
    logic [15:0] DropFrameCnt;

    mii_elastic_buff #(
        .TCo_C(1), .DataWidth_C(8), .DataDepth_C(DEPTH), .StartLevel_C(START)
    ) dut (
        .SysClk(SysClk), .Reset_N(Reset_N),
        .InMiiClkEn(InMiiClkEn), .InMiiDataEn(InMiiDataEn), .InMiiData(InMiiData),
        .OutMiiClkEn(OutMiiClkEn), .OutMiiDataEn(OutMiiDataEn), .OutMiiData(OutMiiData),
        .OutMiiErr(OutMiiErr), .BuffLevel(BuffLevel), .OverflowPls(OverflowPls),
        .UnderflowPls(UnderflowPls), .DropFrameCnt(DropFrameCnt)
    );

    initial begin
        SysClk = 1'b0;
        forever #5 SysClk = ~SysClk;
    end

    typedef struct packed { logic sof; logic [7:0] d; } ent_t;
    typedef struct packed { logic de;  logic [7:0] d; } in_t;

    int n_checks = 0, n_errors = 0;

    // reference model state
    ent_t       mq[$];
    int         m_mode;
    bit         m_en, m_err, m_ovf, m_unf, m_inf, m_drop;
    logic [7:0] m_data;
    logic [15:0] m_dcnt;

    // stimulus and observation
    in_t        stim[$];
    logic [7:0] outq[$], expq[$];
    int         cyc = 0, first_in, first_out;
    int         n_en, n_rise, n_err, n_ovf, n_unf;
    bit         prev_en;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_mode = M_IDLE;
        {m_en, m_err, m_ovf, m_unf, m_inf, m_drop} = '0;
        m_data = '0;
        m_dcnt = '0;
    endtask

    task automatic model_edge(input bit ice, input bit ide, input logic [7:0] id, input bit oce);
        int unsigned pre;
        ent_t h;
        pre = mq.size();
        m_ovf = 0;
        m_unf = 0;
        if (oce) begin
            case (m_mode)
                M_IDLE: begin
                    m_en = 0; m_err = 0;
                    if (pre >= START || (pre != 0 && !m_inf)) begin
                        h = mq.pop_front(); m_en = 1; m_data = h.d; m_mode = M_SEND;
                    end
                end
                M_SEND: begin
                    m_err = 0;
                    if (pre != 0 && !mq[0].sof) begin
                        h = mq.pop_front(); m_en = 1; m_data = h.d;
                    end else if (pre != 0 || !m_inf) begin
                        m_en = 0; m_mode = M_IDLE;
                    end else begin
                        m_en = 1; m_err = 1; m_data = 8'h00; m_unf = 1; m_mode = M_ABORT;
                    end
                end
                default: begin
                    m_en = 0; m_err = 0;
                    if (pre != 0 && !mq[0].sof) h = mq.pop_front();
                    else if (pre != 0 || !m_inf) m_mode = M_IDLE;
                end
            endcase
        end
        if (ice) begin
            if (ide) begin
                if (pre == DEPTH || m_drop) begin
                    m_ovf = 1;
                    if (!m_drop && m_dcnt != 16'hFFFF) m_dcnt++;
                    m_drop = 1;
                end else begin
                    mq.push_back(ent_t'{sof: !m_inf, d: id});
                end
            end else begin
                m_drop = 0;
            end
            m_inf = ide;
        end
    endtask

    task automatic step(input bit ice, input bit ide, input logic [7:0] id, input bit oce);
        InMiiClkEn = ice; InMiiDataEn = ide; InMiiData = id; OutMiiClkEn = oce;
        @(posedge SysClk);
        model_edge(ice, ide, id, oce);
        #1;
        check("en", OutMiiDataEn, m_en);
        check("err", OutMiiErr, m_err);
        if (m_en) check("data", OutMiiData, m_err ? 8'h00 : m_data);
        check("level", BuffLevel, mq.size());
        check("ovf_pls", OverflowPls, m_ovf);
        check("unf_pls", UnderflowPls, m_unf);
        check("drop_cnt", DropFrameCnt, m_dcnt);
        if (oce && OutMiiDataEn) begin
            n_en++;
            if (!OutMiiErr) outq.push_back(OutMiiData);
        end
        if (oce && OutMiiErr) n_err++;
        if (OutMiiDataEn && first_out < 0) first_out = cyc;
        if (OutMiiDataEn && !prev_en) n_rise++;
        if (OverflowPls) n_ovf++;
        if (UnderflowPls) n_unf++;
        prev_en = OutMiiDataEn;
        cyc++;
    endtask

    task automatic drive_stream(input int unsigned wdiv, input int unsigned rdiv,
                                input int unsigned wpct, input int unsigned rpct,
                                input int unsigned tail, input int unsigned max_cyc,
                                output bit done);
        int unsigned k, idle;
        bit ice, oce;
        in_t it;
        k = 0; idle = 0; done = 0;
        while (k < max_cyc) begin
            ice = (wdiv != 0) ? ((k % wdiv) == 0) : ($urandom_range(99) < wpct);
            oce = (rdiv != 0) ? ((k % rdiv) == 0) : ($urandom_range(99) < rpct);
            it = '0;
            if (ice && stim.size() != 0) it = stim.pop_front();
            if (ice && it.de && first_in < 0) first_in = cyc;
            step(ice, it.de, it.d, oce);
            k++;
            if (stim.size() == 0) idle++;
            if (idle >= tail) begin
                done = 1;
                break;
            end
        end
    endtask

    task automatic push_frame(input int n, input logic [7:0] base, input bit rnd);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = rnd ? 8'($urandom) : base + 8'(i);
            stim.push_back(in_t'{de: 1'b1, d: d});
            expq.push_back(d);
        end
    endtask

    task automatic push_gap(input int n);
        for (int i = 0; i < n; i++) stim.push_back(in_t'{de: 1'b0, d: 8'h00});
    endtask

    task automatic clear_obs();
        outq.delete(); expq.delete(); stim.delete();
        first_in = -1; first_out = -1;
        n_en = 0; n_rise = 0; n_err = 0; n_ovf = 0; n_unf = 0;
    endtask

    task automatic check_bytes(input string tag);
        check({tag, "_count"}, outq.size(), expq.size());
        for (int i = 0; i < outq.size() && i < expq.size(); i++)
            check({tag, "_byte"}, outq[i], expq[i]);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_en"}, OutMiiDataEn, 0);
        check({tag, "_err"}, OutMiiErr, 0);
        check({tag, "_data"}, OutMiiData, 0);
        check({tag, "_level"}, BuffLevel, 0);
        check({tag, "_ovf"}, OverflowPls, 0);
        check({tag, "_unf"}, UnderflowPls, 0);
        check({tag, "_dcnt"}, DropFrameCnt, 0);
    endtask

    task automatic do_reset(input string tag);
        Reset_N = 1'b0;
        InMiiClkEn = 0; InMiiDataEn = 0; InMiiData = 0; OutMiiClkEn = 0;
        #1;
        check_idle_outputs(tag);
        model_reset();
        prev_en = 0;
        @(posedge SysClk);
        #1;
        Reset_N = 1'b1;
    endtask

    initial begin
        bit done;
        int n;
        clear_obs();
        prev_en = 0;
        Reset_N = 1'b0;
        InMiiClkEn = 0; InMiiDataEn = 0; InMiiData = 0; OutMiiClkEn = 0;
        model_reset();
        #3;
        check_idle_outputs("rst");
        @(posedge SysClk);
        #1;
        Reset_N = 1'b1;

        // 64-byte frame, both strobes every cycle
        clear_obs();
        push_frame(64, 8'h00, 0);
        push_gap(1);
        drive_stream(1, 1, 0, 0, 40, 2000, done);
        check("s1_done", done, 1);
        check("s1_latency", first_out - first_in, START);
        check("s1_en_cycles", n_en, 64);
        check("s1_rise", n_rise, 1);
        check("s1_err", n_err, 0);
        check_bytes("s1");

        // short frame released on frame end
        clear_obs();
        push_frame(3, 8'h50, 0);
        push_gap(1);
        drive_stream(1, 1, 0, 0, 20, 500, done);
        check("s2_done", done, 1);
        check_bytes("s2");
        check("s2_rise", n_rise, 1);
        check("s2_level_end", BuffLevel, 0);
        check("s2_en_end", OutMiiDataEn, 0);

        // overflow: write every cycle, read every 2nd
        clear_obs();
        push_frame(100, 8'h00, 0);
        push_gap(1);
        drive_stream(1, 2, 0, 0, 80, 2000, done);
        check("s3_done", done, 1);
        check("s3_dropcnt", DropFrameCnt, 1);
        check("s3_ovf_seen", n_ovf != 0, 1);
        check("s3_unf", n_unf, 1);
        check("s3_errbytes", n_err, 1);
        check("s3_short", outq.size() < 100, 1);
        for (int i = 0; i < outq.size(); i++) check("s3_prefix", outq[i], 8'(i));
        check("s3_level_end", BuffLevel, 0);

        // underflow: write every 3rd cycle, read every cycle, then a clean short frame
        clear_obs();
        push_frame(40, 8'h10, 0);
        push_gap(1);
        push_frame(5, 8'hA0, 0);
        push_gap(1);
        drive_stream(3, 1, 0, 0, 60, 2000, done);
        check("s4_done", done, 1);
        check("s4_unf", n_unf, 1);
        check("s4_errbytes", n_err, 1);
        n = outq.size();
        check("s4_size_ok", (n >= 5) && (n < 45), 1);
        if (n >= 5) begin
            for (int i = 0; i < n - 5; i++) check("s4_prefix", outq[i], 8'h10 + 8'(i));
            for (int j = 0; j < 5; j++) check("s4_next_frame", outq[n - 5 + j], 8'hA0 + 8'(j));
        end
        check("s4_level_end", BuffLevel, 0);

        // back-to-back frames separated by a one-strobe gap
        clear_obs();
        push_frame(10, 8'h00, 1);
        push_gap(1);
        push_frame(10, 8'h00, 1);
        push_gap(1);
        drive_stream(1, 1, 0, 0, 30, 500, done);
        check("s5_done", done, 1);
        check_bytes("s5");
        check("s5_rise", n_rise, 2);

        // reset in the middle of SEND, then a clean frame
        clear_obs();
        push_frame(20, 8'h00, 1);
        drive_stream(1, 1, 0, 0, 1000, 12, done);
        check("s6_sending", OutMiiDataEn, 1);
        do_reset("s6_rst");
        clear_obs();
        push_gap(1);
        push_frame(12, 8'h00, 1);
        push_gap(1);
        drive_stream(1, 1, 0, 0, 30, 500, done);
        check("s6_done", done, 1);
        check_bytes("s6");
        check("s6_rise", n_rise, 1);

        // randomized traffic with random strobe densities
        for (int r = 0; r < 6; r++) begin
            clear_obs();
            for (int f = 0; f < 8; f++) begin
                push_frame($urandom_range(30, 1), 8'h00, 1);
                push_gap($urandom_range(3, 1));
            end
            drive_stream(0, 0, $urandom_range(100, 30), $urandom_range(100, 40), 200, 20000, done);
            check("s7_done", done, 1);
            check("s7_drained", BuffLevel, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
